btct_mem_sequencer: RTL and testbench
=====================================

Name: btct_mem_sequencer

Overview:
- Top-level sequencer for the Huffman build-tree (BT) and code-transform (CT) stage. It owns the single-port on-chip SRAM and runs BT, then CT, after one all_start pulse.
- While a stage is active, it grants the SRAM to that engine only. The host init port (ini_*) gets the SRAM only when no stage is active.
- Maps each requester's 10-bit local address into the 16-bit SRAM space. Registers read data back to the requester.
- A watchdog flags an engine that never reports finish.

Parameters:
- INI_BASE, 16'h0000: SRAM base added to ini_addr
- BT_BASE, 16'h0000: SRAM base added to bt_addr
- CT_BASE, 16'h0000: SRAM base added to ct_addr
- TIMEOUT, 20'd1000000: maximum cycles a stage may run before the error state

Ports:
- clk  in  1  system clock, all state on rising edge
- n_rst  in  1  synchronous, active-high reset (1 = reset on next clk edge)
- all_start  in  1  one-cycle pulse; starts the BT-then-CT sequence
- all_finish  out  1  level; high in DONE
- busy  out  1  high in BT_GO, BT_RUN, CT_GO, CT_RUN
- error  out  1  level; high in ERR
- ini_R  in  1  host read request
- ini_W  in  1  host write request
- ini_addr  in  10  host local address
- ini_data_W  in  8  host write data
- ini_data_R  out  8  registered host read data
- bt_start  out  1  one-cycle start pulse to BT
- bt_finish  in  1  BT done pulse
- bt_R  in  1  BT read request
- bt_W  in  1  BT write request
- bt_addr  in  10  BT local address
- bn_data  in  8  BT write data
- fm_data  out  8  registered read data to BT
- ct_start  out  1  one-cycle start pulse to CT
- ct_finish  in  1  CT done pulse
- ct_R  in  1  CT read request
- ct_W  in  1  CT write request
- ct_addr  in  10  CT local address
- rc_data  in  8  CT write data
- sn_data  out  8  registered read data to CT
- mem_R  out  1  SRAM read enable
- mem_W  out  1  SRAM write enable
- mem_addr  out  16  SRAM address
- mem_data_W  out  8  SRAM write data
- mem_data_R  in  8  SRAM read data, valid in the same cycle as mem_R

Behaviour:
- Reset (n_rst=1 at edge) gives:
  - state=IDLE
  - all_finish=0, busy=0, error=0, bt_start=0, ct_start=0
  - ini_data_R, fm_data, sn_data = 8'h00
  - watchdog=0
  - Reset mid-run aborts the stage; start/finish inputs are ignored until IDLE is reached.
- States and transitions:
  - IDLE: all_start -> BT_GO.
  - BT_GO: bt_start=1 for exactly this cycle; watchdog cleared -> BT_RUN.
  - BT_RUN: bt_finish -> CT_GO; watchdog==TIMEOUT-1 -> ERR.
  - CT_GO: ct_start=1 for this cycle; watchdog cleared -> CT_RUN.
  - CT_RUN: ct_finish -> DONE; timeout -> ERR.
  - DONE: all_finish=1; all_start -> BT_GO (restart allowed).
  - ERR: error=1; stays until all_start (-> BT_GO) or reset.
- Watchdog: 20-bit counter, increments each cycle in BT_RUN and CT_RUN; saturates, no wrap.
- all_start outside IDLE/DONE/ERR is ignored. A finish pulse from the non-active engine is ignored.
- SRAM grant is purely combinational on state:
  - IDLE, DONE, ERR: host granted.
  - BT_RUN: BT granted.
  - CT_RUN: CT granted.
  - BT_GO, CT_GO: nobody granted; mem_R=mem_W=0.
- Requests from a non-granted requester are dropped silently.
- Granted requester drives the SRAM:
  - mem_addr = base + {6'b0, addr}, modulo 2^16 (wraps).
  - mem_W = req_W; mem_R = req_R & ~req_W (write wins on simultaneous R/W).
  - mem_data_W = granted write data; 8'h00 when no write.
- Read return:
  - On a granted read cycle, mem_data_R is captured at that edge into the requester's data register; visible one cycle later.
  - The register holds its value until the next granted read by that requester.
- No back-pressure: one access per cycle, every granted request completes.

Decomposition:
- Package btct_pkg holds:
  - seq_state_t enum: IDLE, BT_GO, BT_RUN, CT_GO, CT_RUN, DONE, ERR
  - grant_t enum: G_NONE, G_INI, G_BT, G_CT
  - address-width constants LADDR_W=10, MADDR_W=16
- One sub-module, btct_mem_mux: combinational grant -> mem_* mux plus address offset. The FSM, watchdog and read-return registers stay in btct_mem_sequencer.

Test Plan:
- Host write/read in IDLE, INI_BASE=16'h0100: write ini_addr=10'h005 data=8'hA5, then read -> mem_addr=16'h0105, mem_W for one cycle; ini_data_R=8'hA5 one cycle after the read.
- Full sequence: all_start -> bt_start high exactly 1 cycle later; bt_finish after 50 cycles -> ct_start pulse; ct_finish -> all_finish=1, busy=0.
- Arbitration: in BT_RUN, drive ini_W=1 and bt_R=1, bt_addr=10'h3FF, BT_BASE=16'h0400 -> only the BT read appears (mem_addr=16'h07FF); the host write never reaches the SRAM.
- Simultaneous bt_R=bt_W=1 -> mem_W=1, mem_R=0, fm_data unchanged. Address wrap: CT_BASE=16'hFFFF, ct_addr=2 -> mem_addr=16'h0001.
- Timeout with TIMEOUT=16: never assert bt_finish -> ERR after 16 BT_RUN cycles, error=1, ct_start never pulses; all_start -> BT_GO.
- Reset in CT_RUN: n_rst=1 for one cycle -> every output takes its reset value next cycle; a ct_finish pulse in the following cycle is ignored (state stays IDLE).

Source files
------------

// File: rtl/btct_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : btct_pkg
//  Description : Shared types and constants for the BT/CT memory sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package btct_pkg;

    localparam int LADDR_W  = 10;   // requester-local address width
    localparam int MADDR_W  = 16;   // SRAM address width
    localparam int c_data_w = 8;    // SRAM data width
    localparam int c_wdog_w = 20;   // watchdog counter width

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BT_GO  = 3'd1,
        BT_RUN = 3'd2,
        CT_GO  = 3'd3,
        CT_RUN = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } seq_state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_INI  = 2'd1,
        G_BT   = 2'd2,
        G_CT   = 2'd3
    } grant_t;

    // SRAM ownership depends only on the sequencer state; the launch
    // states leave the SRAM idle so no engine sees a half-cycle grant.
    function automatic grant_t grant_of(input seq_state_t state);
        grant_t g;
        case (state)
            IDLE, DONE, ERR: g = G_INI;
            BT_RUN:          g = G_BT;
            CT_RUN:          g = G_CT;
            default:         g = G_NONE;
        endcase
        return g;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btct_mem_mux.sv
`default_nettype none
// ============================================================================
//  Module      : btct_mem_mux
//  Description : Combinational SRAM port mux. Selects the granted requester,
//                offsets its local address into SRAM space and gates R/W.
//  Revision    : 1.0 - initial release
// ============================================================================
module btct_mem_mux
    import btct_pkg::*;
#(
    parameter logic [MADDR_W-1:0] INI_BASE = 16'h0000,
    parameter logic [MADDR_W-1:0] BT_BASE  = 16'h0000,
    parameter logic [MADDR_W-1:0] CT_BASE  = 16'h0000
) (
    input  grant_t                grant,
    input  logic                  ini_R,
    input  logic                  ini_W,
    input  logic [LADDR_W-1:0]    ini_addr,
    input  logic [c_data_w-1:0]   ini_data_W,
    input  logic                  bt_R,
    input  logic                  bt_W,
    input  logic [LADDR_W-1:0]    bt_addr,
    input  logic [c_data_w-1:0]   bn_data,
    input  logic                  ct_R,
    input  logic                  ct_W,
    input  logic [LADDR_W-1:0]    ct_addr,
    input  logic [c_data_w-1:0]   rc_data,
    output logic                  mem_R,
    output logic                  mem_W,
    output logic [MADDR_W-1:0]    mem_addr,
    output logic [c_data_w-1:0]   mem_data_W
);

    logic                  w_req_R;
    logic                  w_req_W;
    logic [LADDR_W-1:0]    w_laddr;
    logic [c_data_w-1:0]   w_wdata;
    logic [MADDR_W-1:0]    w_base;

    // Select the granted requester; ungranted requests are simply not seen.
    always_comb begin
        w_req_R = 1'b0;
        w_req_W = 1'b0;
        w_laddr = '0;
        w_wdata = '0;
        w_base  = '0;
        case (grant)
            G_INI: begin
                w_req_R = ini_R;
                w_req_W = ini_W;
                w_laddr = ini_addr;
                w_wdata = ini_data_W;
                w_base  = INI_BASE;
            end
            G_BT: begin
                w_req_R = bt_R;
                w_req_W = bt_W;
                w_laddr = bt_addr;
                w_wdata = bn_data;
                w_base  = BT_BASE;
            end
            G_CT: begin
                w_req_R = ct_R;
                w_req_W = ct_W;
                w_laddr = ct_addr;
                w_wdata = rc_data;
                w_base  = CT_BASE;
            end
            default: ;
        endcase
    end

    // Drive the SRAM: writes win over reads, address offset wraps at 2^16.
    always_comb begin
        mem_W      = w_req_W;
        mem_R      = w_req_R & ~w_req_W;
        mem_addr   = w_base + {{(MADDR_W-LADDR_W){1'b0}}, w_laddr};
        mem_data_W = w_req_W ? w_wdata : '0;
    end

endmodule
`default_nettype wire

// File: rtl/btct_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : btct_mem_sequencer
//  Description : Runs the build-tree then code-transform engines after one
//                start pulse, owns the shared SRAM, returns read data and
//                watches each stage for a missing finish.
//  Revision    : 1.0 - initial release
// ============================================================================
module btct_mem_sequencer
    import btct_pkg::*;
#(
    parameter logic [MADDR_W-1:0]  INI_BASE = 16'h0000,
    parameter logic [MADDR_W-1:0]  BT_BASE  = 16'h0000,
    parameter logic [MADDR_W-1:0]  CT_BASE  = 16'h0000,
    parameter logic [c_wdog_w-1:0] TIMEOUT  = 20'd1000000
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  all_start,
    output logic                  all_finish,
    output logic                  busy,
    output logic                  error,
    input  logic                  ini_R,
    input  logic                  ini_W,
    input  logic [LADDR_W-1:0]    ini_addr,
    input  logic [c_data_w-1:0]   ini_data_W,
    output logic [c_data_w-1:0]   ini_data_R,
    output logic                  bt_start,
    input  logic                  bt_finish,
    input  logic                  bt_R,
    input  logic                  bt_W,
    input  logic [LADDR_W-1:0]    bt_addr,
    input  logic [c_data_w-1:0]   bn_data,
    output logic [c_data_w-1:0]   fm_data,
    output logic                  ct_start,
    input  logic                  ct_finish,
    input  logic                  ct_R,
    input  logic                  ct_W,
    input  logic [LADDR_W-1:0]    ct_addr,
    input  logic [c_data_w-1:0]   rc_data,
    output logic [c_data_w-1:0]   sn_data,
    output logic                  mem_R,
    output logic                  mem_W,
    output logic [MADDR_W-1:0]    mem_addr,
    output logic [c_data_w-1:0]   mem_data_W,
    input  logic [c_data_w-1:0]   mem_data_R
);

    localparam logic [c_wdog_w-1:0] c_wdog_last = TIMEOUT - 20'd1;

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [c_wdog_w-1:0]    r_wdog;
    logic                   w_wdog_hit;
    grant_t                 w_grant;
    logic [c_data_w-1:0]    r_ini_rd;
    logic [c_data_w-1:0]    r_fm_rd;
    logic [c_data_w-1:0]    r_sn_rd;

    assign w_grant    = grant_of(r_state);
    assign w_wdog_hit = (r_wdog == c_wdog_last);

    // State register.
    always_ff @(posedge clk) begin
        if (n_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state and status outputs; a finish takes priority over a
    // coincident timeout so a stage ending on its last cycle still succeeds.
    always_comb begin
        w_state_nxt = r_state;
        all_finish  = 1'b0;
        busy        = 1'b0;
        error       = 1'b0;
        bt_start    = 1'b0;
        ct_start    = 1'b0;
        case (r_state)
            IDLE: begin
                if (all_start) w_state_nxt = BT_GO;
            end
            BT_GO: begin
                busy        = 1'b1;
                bt_start    = 1'b1;
                w_state_nxt = BT_RUN;
            end
            BT_RUN: begin
                busy = 1'b1;
                if (bt_finish)       w_state_nxt = CT_GO;
                else if (w_wdog_hit) w_state_nxt = ERR;
            end
            CT_GO: begin
                busy        = 1'b1;
                ct_start    = 1'b1;
                w_state_nxt = CT_RUN;
            end
            CT_RUN: begin
                busy = 1'b1;
                if (ct_finish)       w_state_nxt = DONE;
                else if (w_wdog_hit) w_state_nxt = ERR;
            end
            DONE: begin
                all_finish = 1'b1;
                if (all_start) w_state_nxt = BT_GO;
            end
            ERR: begin
                error = 1'b1;
                if (all_start) w_state_nxt = BT_GO;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Watchdog: cleared at each stage launch, counts run cycles, saturates.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_wdog <= '0;
        end else if (r_state == BT_GO || r_state == CT_GO) begin
            r_wdog <= '0;
        end else if ((r_state == BT_RUN || r_state == CT_RUN) && (r_wdog != '1)) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    btct_mem_mux #(
        .INI_BASE (INI_BASE),
        .BT_BASE  (BT_BASE),
        .CT_BASE  (CT_BASE)
    ) u_mem_mux (
        .grant      (w_grant),
        .ini_R      (ini_R),
        .ini_W      (ini_W),
        .ini_addr   (ini_addr),
        .ini_data_W (ini_data_W),
        .bt_R       (bt_R),
        .bt_W       (bt_W),
        .bt_addr    (bt_addr),
        .bn_data    (bn_data),
        .ct_R       (ct_R),
        .ct_W       (ct_W),
        .ct_addr    (ct_addr),
        .rc_data    (rc_data),
        .mem_R      (mem_R),
        .mem_W      (mem_W),
        .mem_addr   (mem_addr),
        .mem_data_W (mem_data_W)
    );

    // Read return: capture SRAM data for whichever requester owned the read.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_ini_rd <= '0;
            r_fm_rd  <= '0;
            r_sn_rd  <= '0;
        end else if (mem_R) begin
            case (w_grant)
                G_INI:   r_ini_rd <= mem_data_R;
                G_BT:    r_fm_rd  <= mem_data_R;
                G_CT:    r_sn_rd  <= mem_data_R;
                default: ;
            endcase
        end
    end

    assign ini_data_R = r_ini_rd;
    assign fm_data    = r_fm_rd;
    assign sn_data    = r_sn_rd;

endmodule
`default_nettype wire

// File: tb/tb_btct_mem_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_btct_mem_sequencer
//  Description : Self-checking bench for btct_mem_sequencer with a
//                behavioural SRAM and a cycle-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_btct_mem_sequencer;

    localparam logic [15:0] c_ini_base = 16'h0100;
    localparam logic [15:0] c_bt_base  = 16'h0400;
    localparam logic [15:0] c_ct_base  = 16'hFFFF;
    localparam int          c_timeout  = 16;

    // model phases, named after the sequence steps
    localparam int PH_IDLE = 0, PH_BT_GO = 1, PH_BT_RUN = 2, PH_CT_GO = 3,
                   PH_CT_RUN = 4, PH_DONE = 5, PH_ERR = 6;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        all_start, all_finish, busy, error;
    logic        ini_R, ini_W;
    logic [9:0]  ini_addr;
    logic [7:0]  ini_data_W, ini_data_R;
    logic        bt_start, bt_finish, bt_R, bt_W;
    logic [9:0]  bt_addr;
    logic [7:0]  bn_data, fm_data;
    logic        ct_start, ct_finish, ct_R, ct_W;
    logic [9:0]  ct_addr;
    logic [7:0]  rc_data, sn_data;
    logic        mem_R, mem_W;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_W;
    logic [7:0]  mem_data_R;

    logic [7:0]  tb_mem [0:65535];

    int n_chk  = 0;
    int n_fail = 0;

    int       m_phase = PH_IDLE;
    int       m_cnt   = 0;
    logic [7:0] m_ini = 8'h00, m_fm = 8'h00, m_sn = 8'h00;
    bit       m_valid = 1'b0;

    always #5 clk = ~clk;

    btct_mem_sequencer #(
        .INI_BASE (c_ini_base),
        .BT_BASE  (c_bt_base),
        .CT_BASE  (c_ct_base),
        .TIMEOUT  (20'd16)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .all_start  (all_start),
        .all_finish (all_finish),
        .busy       (busy),
        .error      (error),
        .ini_R      (ini_R),
        .ini_W      (ini_W),
        .ini_addr   (ini_addr),
        .ini_data_W (ini_data_W),
        .ini_data_R (ini_data_R),
        .bt_start   (bt_start),
        .bt_finish  (bt_finish),
        .bt_R       (bt_R),
        .bt_W       (bt_W),
        .bt_addr    (bt_addr),
        .bn_data    (bn_data),
        .fm_data    (fm_data),
        .ct_start   (ct_start),
        .ct_finish  (ct_finish),
        .ct_R       (ct_R),
        .ct_W       (ct_W),
        .ct_addr    (ct_addr),
        .rc_data    (rc_data),
        .sn_data    (sn_data),
        .mem_R      (mem_R),
        .mem_W      (mem_W),
        .mem_addr   (mem_addr),
        .mem_data_W (mem_data_W),
        .mem_data_R (mem_data_R)
    );

    // behavioural SRAM: combinational read, write on the clock edge
    assign mem_data_R = tb_mem[mem_addr];
    always @(posedge clk) begin
        if (mem_W) tb_mem[mem_addr] <= mem_data_W;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: settle, compare all outputs against the model, advance the
    // model with the inputs the edge will see, then move to the next negedge.
    task automatic cycle();
        int   owner;
        int   a;
        int   d;
        bit   r, w;
        #1;
        if (m_phase == PH_IDLE || m_phase == PH_DONE || m_phase == PH_ERR) owner = 1;
        else if (m_phase == PH_BT_RUN) owner = 2;
        else if (m_phase == PH_CT_RUN) owner = 3;
        else owner = 0;
        r = 0; w = 0; a = 0; d = 0;
        case (owner)
            1: begin a = (int'(c_ini_base) + int'(ini_addr)) % 65536; w = ini_W; r = ini_R && !ini_W; d = ini_W ? int'(ini_data_W) : 0; end
            2: begin a = (int'(c_bt_base)  + int'(bt_addr))  % 65536; w = bt_W;  r = bt_R  && !bt_W;  d = bt_W  ? int'(bn_data)    : 0; end
            3: begin a = (int'(c_ct_base)  + int'(ct_addr))  % 65536; w = ct_W;  r = ct_R  && !ct_W;  d = ct_W  ? int'(rc_data)    : 0; end
            default: ;
        endcase
        if (m_valid) begin
            check_val("busy",       busy,       (m_phase >= PH_BT_GO && m_phase <= PH_CT_RUN));
            check_val("all_finish", all_finish, (m_phase == PH_DONE));
            check_val("error",      error,      (m_phase == PH_ERR));
            check_val("bt_start",   bt_start,   (m_phase == PH_BT_GO));
            check_val("ct_start",   ct_start,   (m_phase == PH_CT_GO));
            check_val("ini_data_R", ini_data_R, m_ini);
            check_val("fm_data",    fm_data,    m_fm);
            check_val("sn_data",    sn_data,    m_sn);
            check_val("mem_R",      mem_R,      r);
            check_val("mem_W",      mem_W,      w);
            check_val("mem_data_W", mem_data_W, d);
            if (owner != 0) check_val("mem_addr", mem_addr, a);
        end
        if (n_rst) begin
            m_phase = PH_IDLE; m_cnt = 0;
            m_ini = 8'h00; m_fm = 8'h00; m_sn = 8'h00;
            m_valid = 1'b1;
        end else begin
            if (r) begin
                case (owner)
                    1: m_ini = tb_mem[a[15:0]];
                    2: m_fm  = tb_mem[a[15:0]];
                    3: m_sn  = tb_mem[a[15:0]];
                    default: ;
                endcase
            end
            case (m_phase)
                PH_IDLE, PH_DONE, PH_ERR: if (all_start) m_phase = PH_BT_GO;
                PH_BT_GO: begin m_phase = PH_BT_RUN; m_cnt = 0; end
                PH_CT_GO: begin m_phase = PH_CT_RUN; m_cnt = 0; end
                PH_BT_RUN: begin
                    if (bt_finish) m_phase = PH_CT_GO;
                    else if (m_cnt == c_timeout - 1) m_phase = PH_ERR;
                    m_cnt++;
                end
                PH_CT_RUN: begin
                    if (ct_finish) m_phase = PH_DONE;
                    else if (m_cnt == c_timeout - 1) m_phase = PH_ERR;
                    m_cnt++;
                end
                default: ;
            endcase
        end
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        all_start = 0; bt_finish = 0; ct_finish = 0;
        ini_R = 0; ini_W = 0; ini_addr = '0; ini_data_W = '0;
        bt_R = 0;  bt_W = 0;  bt_addr = '0;  bn_data = '0;
        ct_R = 0;  ct_W = 0;  ct_addr = '0;  rc_data = '0;
    endtask

    initial begin
        logic [7:0] fm_before;
        for (int i = 0; i < 65536; i++) tb_mem[i] = 8'($urandom);
        n_rst = 1;
        idle_inputs();
        @(negedge clk);
        cycle(); cycle();
        n_rst = 0;
        cycle();

        // host write then read in IDLE
        ini_W = 1; ini_addr = 10'h005; ini_data_W = 8'hA5;
        #1 check_val("ini_wr_addr", mem_addr, 16'h0105);
        cycle();
        ini_W = 0; ini_R = 1;
        cycle();
        ini_R = 0;
        check_val("ini_rd_data", ini_data_R, 8'hA5);
        cycle();

        // full sequence with arbitration, R/W collision and address wrap
        all_start = 1; cycle(); all_start = 0;
        check_val("bt_start_pulse", bt_start, 1'b1);
        cycle();
        ini_W = 1; ini_addr = 10'h005; ini_data_W = 8'h5A;
        bt_R = 1; bt_addr = 10'h3FF;
        #1 check_val("bt_rd_addr", mem_addr, 16'h07FF);
        check_val("ini_blocked", mem_W, 1'b0);
        cycle();
        fm_before = fm_data;
        bt_W = 1; bn_data = 8'h33;
        cycle();
        bt_R = 0; bt_W = 0; ini_W = 0;
        check_val("fm_hold_on_rw", fm_data, fm_before);
        for (int i = 0; i < 8; i++) cycle();
        bt_finish = 1; cycle(); bt_finish = 0;
        check_val("ct_start_pulse", ct_start, 1'b1);
        cycle();
        ct_R = 1; ct_addr = 10'h002;
        #1 check_val("ct_wrap_addr", mem_addr, 16'h0001);
        cycle();
        ct_R = 0;
        ct_finish = 1; cycle(); ct_finish = 0;
        check_val("seq_done", all_finish, 1'b1);
        check_val("seq_not_busy", busy, 1'b0);
        ini_R = 1; ini_addr = 10'h005; cycle(); ini_R = 0;
        check_val("ini_write_dropped", ini_data_R, 8'hA5);

        // watchdog timeout in BT_RUN
        all_start = 1; cycle(); all_start = 0;
        for (int i = 0; i < 20; i++) cycle();
        check_val("timeout_err", error, 1'b1);
        all_start = 1; cycle(); all_start = 0;
        check_val("err_restart", bt_start, 1'b1);

        // reset while CT_RUN, then a stray ct_finish
        cycle();
        bt_finish = 1; cycle(); bt_finish = 0;
        cycle(); cycle();
        n_rst = 1; cycle(); n_rst = 0;
        check_val("rst_busy", busy, 1'b0);
        ct_finish = 1; cycle(); ct_finish = 0;
        check_val("rst_no_done", all_finish, 1'b0);
        cycle();

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            n_rst      = ($urandom_range(0, 199) == 0);
            all_start  = ($urandom_range(0, 11) == 0);
            bt_finish  = ($urandom_range(0, 19) == 0);
            ct_finish  = ($urandom_range(0, 19) == 0);
            ini_R = 1'($urandom); ini_W = 1'($urandom);
            ini_addr = 10'($urandom); ini_data_W = 8'($urandom);
            bt_R = 1'($urandom); bt_W = 1'($urandom);
            bt_addr = 10'($urandom); bn_data = 8'($urandom);
            ct_R = 1'($urandom); ct_W = 1'($urandom);
            ct_addr = 10'($urandom); rc_data = 8'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
